mem_ctrl_pipe: RTL and testbench

Parametrised single-port memory controller, the successor to the fixed 8-bit/16-bit-address controller. It adds a valid/ready request handshake, a configurable read-latency pipeline with a rd_valid strobe, and out-of-range address detection. It sits between a request master (CPU/DMA/bench) and an internal register-array memory of DEPTH words.

---
 rtl/mem_ctrl_pipe.sv | 181 ++++++++++++++++++
 tb/tb_mem_ctrl_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pipe.sv
// Parametrised single-port memory controller with valid/ready requests, a RD_LATENCY-deep read pipeline and out-of-range detection.
// Optional power-up clear of the array is enabled by defining MEM_CTRL_CLEAR_EN.
module mem_ctrl_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_wr_valid,
  input  logic                  rd_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ERR_W = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  state_t                state_r, state_next_s;
  logic                  req_ready_r, addr_err_r, busy_r;
  logic                  accept_s, in_range_s, rd_acc_s, wr_ok_s, wr_oor_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  mem_we_s;
  logic [IDX_W-1:0]      mem_widx_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] pipe_data_r [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld_r;
  logic [ERR_W-1:0]      pipe_err_r;
  logic [DATA_WIDTH-1:0] stg_data_s [RD_LATENCY];
  logic [RD_LATENCY-1:0] stg_vld_s, stg_err_s;

  // Range check happens on the full address; only then are the low bits used as the index.
  assign in_range_s = addr_in_range(addr);
  assign idx_s      = addr[IDX_W-1:0];
  assign accept_s   = reset_n & rd_wr_valid & req_ready_r;
  assign rd_acc_s   = accept_s & rd_wr;
  assign wr_ok_s    = accept_s & ~rd_wr & in_range_s;
  assign wr_oor_s   = accept_s & ~rd_wr & ~in_range_s;

`ifdef MEM_CTRL_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt_r;
  logic             clr_last_s;

  assign clr_last_s = (clr_cnt_r == IDX_W'(DEPTH - 1));

  // Clear counter walks every word once while in INIT and restarts on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clr_cnt_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_INIT) begin
      clr_cnt_r <= clr_cnt_r + IDX_W'(1'b1);
    end
  end
`endif

  // Next-state logic for the INIT -> ACTIVE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
`ifdef MEM_CTRL_CLEAR_EN
        if (clr_last_s) begin
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_INIT;
        end
`else
        state_next_s = ST_ACTIVE;
`endif
      end
      ST_ACTIVE: state_next_s = ST_ACTIVE;
      default:   state_next_s = ST_INIT;
    endcase
  end

  // State register plus registered ready/busy derived from the next-cycle view.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      req_ready_r <= (state_next_s == ST_ACTIVE);
      busy_r      <= (state_next_s != ST_ACTIVE) | (|stg_vld_s);
    end
  end

  // Array write port: clear sweep during INIT, otherwise accepted in-range writes.
  always_comb begin
    mem_we_s    = wr_ok_s;
    mem_widx_s  = idx_s;
    mem_wdata_s = wr_data;
`ifdef MEM_CTRL_CLEAR_EN
    if (reset_n && (state_r == ST_INIT)) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = clr_cnt_r;
      mem_wdata_s = {DATA_WIDTH{1'b0}};
    end else begin
      mem_we_s    = wr_ok_s;
      mem_widx_s  = idx_s;
      mem_wdata_s = wr_data;
    end
`endif
  end

  // Memory array; contents intentionally have no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Inputs to each pipe stage; stage 0 samples the array, later stages shift.
  always_comb begin
    stg_vld_s = {RD_LATENCY{1'b0}};
    stg_err_s = {RD_LATENCY{1'b0}};
    for (int i = 0; i < RD_LATENCY; i++) begin
      stg_data_s[i] = {DATA_WIDTH{1'b0}};
    end
    stg_vld_s[0] = rd_acc_s;
    stg_err_s[0] = ~in_range_s;
    if (in_range_s) begin
      stg_data_s[0] = mem_r[idx_s];
    end else begin
      stg_data_s[0] = {DATA_WIDTH{1'b0}};
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      stg_vld_s[i]  = pipe_vld_r[i-1];
      stg_data_s[i] = pipe_data_r[i-1];
      stg_err_s[i]  = pipe_err_r[i-1];
    end
  end

  // Read pipeline; data registers hold when no read passes so rd_data keeps its last value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_vld_r <= {RD_LATENCY{1'b0}};
      pipe_err_r <= {ERR_W{1'b0}};
      addr_err_r <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      pipe_vld_r <= stg_vld_s;
      for (int i = 0; i < RD_LATENCY; i++) begin
        if (stg_vld_s[i]) begin
          pipe_data_r[i] <= stg_data_s[i];
        end
      end
      for (int i = 0; i < ERR_W; i++) begin
        pipe_err_r[i] <= stg_err_s[i];
      end
      addr_err_r <= wr_oor_s | (stg_vld_s[RD_LATENCY-1] & stg_err_s[RD_LATENCY-1]);
    end
  end

  assign req_ready = req_ready_r;
  assign rd_data   = pipe_data_r[RD_LATENCY-1];
  assign rd_valid  = pipe_vld_r[RD_LATENCY-1];
  assign addr_err  = addr_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_ctrl_pipe.sv
// Scoreboard bench for mem_ctrl_pipe: reads push expected data/latency, a negedge monitor pops and compares.
// Define MEM_CTRL_CLEAR_EN to exercise the power-up clear build with DEPTH=16.
module tb_mem_ctrl_pipe;

  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int LAT = 2;
`ifdef MEM_CTRL_CLEAR_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 256;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_wr_valid;
  logic          rd_wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          req_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          addr_err;
  logic          busy;

  always #5 clk = ~clk;

  mem_ctrl_pipe #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rd_wr_valid(rd_wr_valid),
    .rd_wr(rd_wr),
    .addr(addr),
    .wr_data(wr_data),
    .req_ready(req_ready),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .addr_err(addr_err),
    .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] model [DEPTH];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            wr_err_due = -1;
  bit            mon_en = 1'b0;
  exp_t          head;
  logic          exp_rv;
  logic          exp_ae;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle compares rd_valid/addr_err against the scoreboard, and rd_data on a pop.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rv = 1'b0;
      exp_ae = (cyc == wr_err_due);
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        head   = sb_q.pop_front();
        exp_rv = 1'b1;
        exp_ae = exp_ae | head.err;
      end
      checks++;
      if (rd_valid !== exp_rv) begin
        failures++;
        $display("FAIL rd_valid cyc=%0d: got %b expected %b", cyc, rd_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (rd_data !== head.data) begin
          failures++;
          $display("FAIL rd_data cyc=%0d: got %0h expected %0h", cyc, rd_data, head.data);
        end
      end
      checks++;
      if (addr_err !== exp_ae) begin
        failures++;
        $display("FAIL addr_err cyc=%0d: got %b expected %b", cyc, addr_err, exp_ae);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request accepted at the next edge; expectations come from the bench's own memory model.
  task automatic do_req(input logic rw, input int a, input logic [DW-1:0] d);
    exp_t e;
    rd_wr_valid = 1'b1;
    rd_wr       = rw;
    addr        = AW'(a);
    wr_data     = d;
    @(posedge clk);
    #1;
    if (rw) begin
      e.data = (a < DEPTH) ? model[a] : {DW{1'b0}};
      e.err  = (a >= DEPTH);
      e.due  = cyc + LAT - 1;
      sb_q.push_back(e);
    end else if (a < DEPTH) begin
      model[a] = d;
    end else begin
      wr_err_due = cyc;
    end
    rd_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rd_wr_valid = 1'b0;
    rd_wr = 1'b0;
    addr = '0;
    wr_data = '0;
    idle(2);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b expected 1", busy); end
    mon_en = 1'b1;
  endtask

  task automatic test_release();
    reset_n = 1'b1;
    idle(1);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    do_req(1'b0, 20, 8'd2);
    do_req(1'b1, 20, 8'd0);
    idle(3);
  endtask

  task automatic test_raw();
    do_req(1'b0, 22, 8'd4);
    do_req(1'b1, 22, 8'd0);
    idle(3);
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 20, 8'd0);
    do_req(1'b1, 22, 8'd0);
    do_req(1'b1, 20, 8'd0);
    idle(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_last: got %b expected 1", busy); end
    idle(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_drop: got %b expected 0", busy); end
    idle(1);
  endtask

  task automatic test_raw_consecutive();
    do_req(1'b0, 22, 8'd9);
    do_req(1'b1, 22, 8'd0);
    idle(3);
  endtask

  task automatic test_out_of_range();
    do_req(1'b0, 44, 8'h5A);
    do_req(1'b0, 300, 8'd7);
    idle(1);
    do_req(1'b1, 300, 8'd0);
    do_req(1'b1, 44, 8'd0);
    idle(3);
    do_req(1'b1, 300, 8'd0);
    do_req(1'b0, 300, 8'd7);
    idle(3);
  endtask

  task automatic test_reset_mid();
    do_req(1'b1, 20, 8'd0);
    reset_n = 1'b0;
    idle(1);
    sb_q.delete();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_reset_busy: got %b expected 1", busy); end
    reset_n = 1'b1;
    idle(1);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_reactive: got %b expected 1", req_ready); end
    idle(3);
  endtask

`ifdef MEM_CTRL_CLEAR_EN
  task automatic check_clear_window();
    for (int n = 1; n <= DEPTH; n++) begin
      idle(1);
      checks++;
      if (req_ready !== (n == DEPTH)) begin
        failures++;
        $display("FAIL clear_req_ready edge=%0d: got %b expected %b", n, req_ready, (n == DEPTH));
      end
    end
  endtask

  task automatic test_clear();
    reset_n = 1'b1;
    check_clear_window();
    for (int i = 0; i < DEPTH; i++) model[i] = {DW{1'b0}};
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, i, 8'd0);
    idle(3);
    do_req(1'b0, 3, 8'hAB);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(5);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    check_clear_window();
    for (int i = 0; i < DEPTH; i++) model[i] = {DW{1'b0}};
    do_req(1'b1, 3, 8'd0);
    do_req(1'b1, 15, 8'd0);
    idle(3);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
`ifdef MEM_CTRL_CLEAR_EN
    test_clear();
`else
    test_release();
    test_basic();
    test_raw();
    test_back_to_back();
    test_raw_consecutive();
    test_out_of_range();
    test_reset_mid();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
